// File: rtl/rx_cic_decim_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_cic_pkg : shared constants and helpers for the receive CIC        |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package rx_cic_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_IN  = 1;

    // Bit growth of an N-stage, M=1 CIC is N*log2(R) on top of the input width.
    function automatic int acc_width(input int in_w, input int stages, input int rate);
        return in_w + stages * $clog2(rate);
    endfunction

    function automatic logic [63:0] round_const(input int acc_w, input int out_w);
        return 64'd1 << (acc_w - out_w - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_cic_decim_comb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cic_comb_stage : registered differentiator with valid/error tags     |
// | Revision       : 1.0                                                  |
// +----------------------------------------------------------------------+
module cic_comb_stage #(
    parameter int W = 44
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clken,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_err,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_err
);

    logic [W-1:0] r_prev;
    logic [W-1:0] r_out;
    logic         r_vld;
    logic         r_err;

    // The tag shifts on every enabled cycle; data and delay only move on valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= '0;
            r_out  <= '0;
            r_vld  <= 1'b0;
            r_err  <= 1'b0;
        end else if (clken) begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_prev <= in_data;
                r_out  <= in_data - r_prev;
                r_err  <= in_err;
            end
        end
    end

    assign out_data  = r_out;
    assign out_valid = r_vld;
    assign out_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/rx_cic_decim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_cic_decim : receive CIC decimator with Avalon-ST source output    |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module rx_cic_decim
    import rx_cic_pkg::*;
#(
    parameter int   IN_W       = 14,
    parameter int   OUT_W      = 16,
    parameter int   STAGES     = 5,
    parameter int   RATE       = 64,
    parameter int   ACC_W      = acc_width(IN_W, STAGES, RATE),
    parameter logic CHANNEL_ID = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clken,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic [1:0]       in_error,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_error,
    output logic             out_startofpacket,
    output logic             out_endofpacket,
    output logic             out_channel
);

    localparam int               CNT_W   = $clog2(RATE);
    localparam logic [ACC_W-1:0] ROUND   = ACC_W'(round_const(ACC_W, OUT_W));
    localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};

    // Front end, decimation counter and integrator cascade
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;
    logic             r_win_err;
    logic [ACC_W-1:0] r_integ [STAGES+1];
    logic [STAGES:0]  r_vld;
    logic [STAGES:0]  r_dec;
    logic [STAGES:0]  r_err;

    logic             w_accept;
    logic             w_decim;
    logic             w_in_bad;
    logic [ACC_W-1:0] w_in_ext;

    assign w_accept = in_valid & clken & r_in_ready;
    assign w_decim  = w_accept & (r_cnt == CNT_W'(RATE - 1));
    assign w_in_bad = |in_error;
    assign w_in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

    // Stage 0 is the input capture register; stages 1..STAGES are integrators.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready <= 1'b0;
            r_cnt      <= '0;
            r_win_err  <= 1'b0;
            r_vld      <= '0;
            r_dec      <= '0;
            r_err      <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                r_integ[k] <= '0;
            end
        end else begin
            r_in_ready <= 1'b1;
            if (clken) begin
                r_vld[0] <= w_accept;
                r_dec[0] <= w_decim;
                r_err[0] <= w_decim & (r_win_err | w_in_bad);
                if (w_accept) begin
                    r_integ[0] <= w_in_ext;
                    r_cnt      <= r_cnt + CNT_W'(1);
                    r_win_err  <= ~w_decim & (r_win_err | w_in_bad);
                end
                for (int k = 1; k <= STAGES; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_dec[k] <= r_dec[k-1];
                    r_err[k] <= r_err[k-1];
                    if (r_vld[k-1]) begin
                        r_integ[k] <= r_integ[k] + r_integ[k-1];
                    end
                end
            end
        end
    end

    // Comb cascade runs at the decimated rate: only decimate-tagged data enters.
    logic [ACC_W-1:0] w_comb_data [STAGES+1];
    logic             w_comb_vld  [STAGES+1];
    logic             w_comb_err  [STAGES+1];

    assign w_comb_data[0] = r_integ[STAGES];
    assign w_comb_vld[0]  = r_vld[STAGES] & r_dec[STAGES];
    assign w_comb_err[0]  = r_err[STAGES];

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_comb
            cic_comb_stage #(
                .W (ACC_W)
            ) u_comb (
                .clk       (clk),
                .reset     (reset),
                .clken     (clken),
                .in_data   (w_comb_data[g]),
                .in_valid  (w_comb_vld[g]),
                .in_err    (w_comb_err[g]),
                .out_data  (w_comb_data[g+1]),
                .out_valid (w_comb_vld[g+1]),
                .out_err   (w_comb_err[g+1])
            );
        end
    endgenerate

    // Round half-up; only a positive value can carry into the sign bit.
    logic [ACC_W-1:0] w_last;
    logic [ACC_W-1:0] w_sum;
    logic             w_sat;
    logic [OUT_W-1:0] w_round;
    logic             w_round_unused;

    assign w_last         = w_comb_data[STAGES];
    assign w_sum          = w_last + ROUND;
    assign w_sat          = ~w_last[ACC_W-1] & w_sum[ACC_W-1];
    assign w_round        = w_sat ? SAT_MAX : w_sum[ACC_W-1 -: OUT_W];
    assign w_round_unused = ^w_sum[ACC_W-OUT_W-1:0];

    logic [OUT_W-1:0] r_res_data;
    logic             r_res_vld;
    logic             r_res_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_res_data <= '0;
            r_res_vld  <= 1'b0;
            r_res_err  <= 1'b0;
        end else if (clken) begin
            r_res_vld <= w_comb_vld[STAGES];
            if (w_comb_vld[STAGES]) begin
                r_res_data <= w_round;
                r_res_err  <= w_comb_err[STAGES];
            end
        end
    end

    // Output holding register. A pending result is consumed on an enabled
    // cycle so each one is either loaded or dropped exactly once.
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_vld;
    logic [1:0]       r_out_err;
    logic             r_ovf;
    logic             w_load;
    logic             w_drop;
    logic [1:0]       w_load_err;

    assign w_load = r_res_vld & clken & (~r_out_vld | out_ready);
    assign w_drop = r_res_vld & clken & r_out_vld & ~out_ready;

    always_comb begin
        w_load_err          = '0;
        w_load_err[ERR_OVF] = r_ovf;
        w_load_err[ERR_IN]  = r_res_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_err  <= '0;
            r_ovf      <= 1'b0;
        end else if (w_load) begin
            r_out_data <= r_res_data;
            r_out_err  <= w_load_err;
            r_out_vld  <= 1'b1;
            r_ovf      <= 1'b0;
        end else begin
            if (r_out_vld & out_ready) begin
                r_out_vld <= 1'b0;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign in_ready          = r_in_ready;
    assign out_data          = r_out_data;
    assign out_valid         = r_out_vld;
    assign out_error         = r_out_err;
    assign out_startofpacket = r_out_vld;
    assign out_endofpacket   = r_out_vld;
    assign out_channel       = CHANNEL_ID;

endmodule
`default_nettype wire

// File: tb/tb_rx_cic_decim.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_cic_decim : directed vector bench for rx_cic_decim             |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_rx_cic_decim;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clken = 1'b1;
    logic [13:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic [1:0]  in_error = '0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_error;
    logic        out_sop;
    logic        out_eop;
    logic        out_channel;

    always #5 clk = ~clk;

    rx_cic_decim dut (
        .clk               (clk),
        .reset             (reset),
        .clken             (clken),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_error          (in_error),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_error         (out_error),
        .out_startofpacket (out_sop),
        .out_endofpacket   (out_eop),
        .out_channel       (out_channel)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [1:0]  err;
        logic        sop;
        logic        eop;
        logic        chan;
    } out_rec_t;

    out_rec_t q[$];
    int       active_cnt    = 0;
    int       first_vld_act = -1;
    int       dec_act       = 0;
    int       acc           = 0;
    bit       ph            = 1'b1;

    always @(posedge clk) if (clken === 1'b1) active_cnt <= active_cnt + 1;

    // Record completed transfers; the handshake is stable at the falling edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && first_vld_act < 0) first_vld_act = active_cnt;
        if (out_valid === 1'b1 && out_ready === 1'b1)
            q.push_back('{out_data, out_error, out_sop, out_eop, out_channel});
    end

    function automatic logic [13:0] pat(input int m, input int mode, input logic [13:0] din);
        if (mode == 0) return din;
        return 14'(((m * 73) % 401) - 200 + ((m % 7 == 0) ? 5000 : 0));
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; clken = 1'b1; in_valid = 1'b0; in_data = '0;
        in_error = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_error", out_error, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        q.delete(); first_vld_act = -1; acc = 0; ph = 1'b1;
    endtask

    // One input cycle; err_at selects the accept index that carries in_error=2'b10.
    task automatic step(input int mode, input logic [13:0] din, input bit gate, input int err_at);
        clken    = gate ? ph : 1'b1;
        ph       = ~ph;
        in_valid = 1'b1;
        in_data  = pat(acc, mode, din);
        in_error = (acc == err_at) ? 2'b10 : 2'b00;
        if (clken) begin
            if (acc == 63) dec_act = active_cnt;
            acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_error = '0; clken = 1'b1;
    endtask

    task automatic collect(input int mode, input logic [13:0] din, input bit gate,
                           input int err_at, input int nout, input int budget);
        int cyc = 0;
        while (q.size() < nout && cyc < budget) begin
            step(mode, din, gate, err_at);
            cyc++;
        end
        check("collect_count", q.size(), nout);
    endtask

    typedef struct {
        logic [13:0] din;
        bit          gate;
        logic [15:0] dout;
    } vec_t;

    vec_t   tbl[7];
    longint st[6][512];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Settled DC gain is 4: RATE^STAGES = 2^30 against a 2^28 output scale.
        tbl[0] = '{14'd1000,  1'b0, 16'd4000};
        tbl[1] = '{14'h2000,  1'b0, 16'h8000};
        tbl[2] = '{14'd8191,  1'b0, 16'd32764};
        tbl[3] = '{14'h3fff,  1'b0, 16'hfffc};
        tbl[4] = '{14'd0,     1'b0, 16'd0};
        tbl[5] = '{14'd1,     1'b0, 16'd4};
        tbl[6] = '{14'd1000,  1'b1, 16'd4000};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            collect(0, tbl[i].din, tbl[i].gate, -1, 7, 1700);
            // Result ready 12 enabled cycles after the decimating accept, loaded on the 13th.
            check($sformatf("v%0d_latency", i), first_vld_act - dec_act, 13);
            if (q.size() >= 7) begin
                check($sformatf("v%0d_out5", i), q[5].data, tbl[i].dout);
                check($sformatf("v%0d_out6", i), q[6].data, tbl[i].dout);
                check($sformatf("v%0d_err", i), {q[5].err, q[6].err}, 0);
                check($sformatf("v%0d_sop_eop_ch", i), {q[6].sop, q[6].eop, q[6].chan}, 3'b110);
            end
        end

        // Non-DC stream against a boxcar-cascade reference (exercises rounding).
        do_reset();
        collect(1, '0, 1'b0, -1, 8, 900);
        for (int m = 0; m < 512; m++) st[0][m] = longint'($signed(pat(m, 1, '0)));
        for (int k = 1; k < 6; k++)
            for (int m = 0; m < 512; m++)
                st[k][m] = ((m > 0) ? st[k][m-1] : 0) + st[k-1][m] - ((m >= 64) ? st[k-1][m-64] : 0);
        if (q.size() >= 8) begin
            for (int n = 0; n < 8; n++) begin
                longint r;
                r = (st[5][n*64+63] + (longint'(1) <<< 27)) >>> 28;
                if (r > 32767) r = 32767;
                check($sformatf("pat_out%0d", n), longint'($signed(q[n].data)), r);
            end
        end

        // Backpressure across two decimation periods.
        do_reset();
        collect(0, 14'd1000, 1'b0, -1, 7, 700);
        out_ready = 1'b0;
        repeat (150) step(0, 14'd1000, 1'b0, -1);
        check("bp_held_valid", out_valid, 1);
        check("bp_held_data", out_data, 4000);
        check("bp_held_err", out_error, 0);
        check("bp_no_transfer", q.size(), 7);
        out_ready = 1'b1;
        collect(0, 14'd1000, 1'b0, -1, 10, 300);
        if (q.size() >= 10) begin
            check("bp_first_err", q[7].err, 2'b00);
            check("bp_ovf_err", q[8].err, 2'b01);
            check("bp_after_err", q[9].err, 2'b00);
            check("bp_ovf_data", q[8].data, 4000);
        end

        // Input error on one sample of window 2.
        do_reset();
        collect(0, 14'd1000, 1'b0, 150, 5, 500);
        if (q.size() >= 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("inerr_win%0d", i), q[i].err, (i == 2) ? 2 : 0);

        // Reset in the middle of a window.
        do_reset();
        repeat (30) step(0, 14'd1000, 1'b0, -1);
        do_reset();
        repeat (64) step(0, 14'd0, 1'b0, -1);
        check("mid_rst_no_valid", out_valid, 0);
        check("mid_rst_no_early", first_vld_act, -1);
        collect(0, 14'd0, 1'b0, -1, 1, 100);
        if (q.size() >= 1) begin
            check("mid_rst_data", q[0].data, 0);
            check("mid_rst_err", q[0].err, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_cic_decim.md
Name: rx_cic_decim

Overview:
- Receive-path CIC decimator, the counterpart of the transmit CIC interpolator.
- Takes 14-bit ADC samples qualified by clken/in_valid, decimates by RATE through a STAGES-order CIC, and rounds to 16 bits.
- Presents the result on an Avalon-ST source with backpressure, error and packet sideband.
- One instance per I/Q rail; sits between the ADC capture register and the receive FIR/DSP chain.

Parameters:
- IN_W, 14, input sample width (two's complement)
- OUT_W, 16, output sample width
- STAGES, 5, number of integrator stages and of comb stages (comb differential delay fixed at 1)
- RATE, 64, decimation factor; must be a power of two, range 4..256
- ACC_W, 44, internal width = IN_W + STAGES*log2(RATE)
- CHANNEL_ID, 0, constant driven on out_channel

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clken  in  1  pipeline advance enable; while low, all state holds
- in_data  in  14  ADC sample
- in_valid  in  1  sample present
- in_error  in  2  upstream error flags (nonzero = bad sample)
- in_ready  out  1  sink ready
- out_data  out  16  decimated sample
- out_valid  out  1  output holding register full
- out_ready  in  1  downstream accepts
- out_error  out  2  bit0 = overflow (samples dropped); bit1 = input error inside window
- out_startofpacket  out  1  equals out_valid (single-sample packets)
- out_endofpacket  out  1  equals out_valid
- out_channel  out  1  CHANNEL_ID

Behaviour:
- Reset state:
  - All integrators, combs, pipeline valid tags and the decimation counter are 0.
  - out_valid=0, out_data=0, out_error=0, in_ready=0 during reset.
  - in_ready=1 from the first cycle after reset deasserts, and stays 1 thereafter. The block never backpressures its input; loss is handled at the output.
- Input acceptance: accept = in_valid & clken & in_ready. Input is sign-extended to ACC_W.
- Integrators:
  - STAGES cascaded, each registered, each updating only on a valid tag.
  - Arithmetic is modulo 2^ACC_W; wrap-around is intended and must not be saturated.
- Decimation counter:
  - 0..RATE-1, increments on accept, wraps to 0.
  - The accept at count RATE-1 tags that sample as "decimate".
- Combs:
  - STAGES registered differentiators, advancing only on decimate-tagged data.
  - Each holds its previous decimated input for the subtraction; modulo ACC_W.
- Output stage:
  - Round half-up: add 2^(ACC_W-OUT_W-1), then take bits [ACC_W-1 : ACC_W-OUT_W].
  - Saturate to +max if the rounding carry overflows the sign.
- Latency: decimating accept at clken-cycle t → result ready to load at t + 2*STAGES + 2 clken-active cycles (12 for defaults).
- Holding register:
  - Loaded when a result is ready and (out_valid=0 or out_ready=1).
  - A transfer completes on out_valid & out_ready.
  - Simultaneous accept and load: the new sample replaces the old one, and out_valid stays 1.
- Overflow:
  - A result arriving while out_valid=1 & out_ready=0 is dropped and a sticky ovf flag is set.
  - ovf is reported as out_error[0] on the next loaded sample, then cleared on that load.
- Input error:
  - Any accepted sample with in_error≠0 sets a window flag.
  - The flag travels with the decimate tag and appears as out_error[1] on that window's output sample.
  - The flag clears at the start of the next window.
- clken low: pipeline, counter and flags hold. The handshake on out_valid/out_ready remains live.
- Reset mid-operation: everything returns to the reset state in the same cycle. A partial window is discarded and no stale output is emitted.
- DC gain:
  - RATE^STAGES / 2^(ACC_W-OUT_W) = 2^30 / 2^28 = 4 for defaults.
  - Full-scale input therefore cannot saturate except through the rounding corner case.

Decomposition:
- Package rx_cic_pkg: ACC_W derivation function (clog2-based), error bit indices (ERR_OVF=0, ERR_IN=1), and rounding constant helper.
- One natural sub-module, cic_comb_stage: a registered differentiator with valid-tag passthrough, instantiated STAGES times. Integrators stay inline.

Test Plan:
- DC step: reset, then clken=1, in_valid=1, in_data=1000 continuously, out_ready=1 → out_valid every 64 cycles; from the 6th output onward out_data=4000 exactly, out_error=0, sop=eop=1.
- Negative full scale: in_data=-8192 constant → settled out_data=-32768, no saturation, no error.
- Backpressure overflow: DC 1000, out_ready=0 across two decimation periods → first sample held unchanged, second dropped; after out_ready=1 the next loaded sample has out_error=2'b01, and the following one 2'b00.
- Input error: in_error=2'b10 on a single sample inside window k → only window k's output has out_error[1]=1.
- clken gating: clken toggled 1/0 each cycle → identical output values to the clken=1 run, at half the rate; latency 12 clken-active cycles.
- Reset mid-window: apply reset after 30 accepts, release, then feed 64 zeros → in_ready=0 during reset, out_valid=0 until the first window completes, out_data=0.
